// File: rtl/circuito_exp4.sv
// Sequence-memory game: 16-entry ROM, play detector, datapath and Moore FSM.
// Define CIRCUITO_EXP4_DEBUG_EN to drive the db_* 7-seg and compare/play outputs.
module circuito_exp4 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        REGISTRA   = 4'h4,
        COMPARACAO = 4'h5,
        PROXIMO    = 4'h6,
        FIM_ACERTO = 4'hA,
        FIM_ERRO   = 4'hE
    } estado_t;

    function automatic logic [3:0] rom(input logic [3:0] a);
        unique case (a)
            4'h0: rom = 4'b0001;  4'h1: rom = 4'b0010;
            4'h2: rom = 4'b0100;  4'h3: rom = 4'b1000;
            4'h4: rom = 4'b0100;  4'h5: rom = 4'b0010;
            4'h6: rom = 4'b0001;  4'h7: rom = 4'b0001;
            4'h8: rom = 4'b0010;  4'h9: rom = 4'b0010;
            4'hA: rom = 4'b0100;  4'hB: rom = 4'b0100;
            4'hC: rom = 4'b1000;  4'hD: rom = 4'b1000;
            4'hE: rom = 4'b0001;  default: rom = 4'b0100;
        endcase
    endfunction

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        unique case (v)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    estado_t    estado_q, estado_d;
    logic [3:0] contagem_q;
    logic [3:0] jogada_q;
    logic       tem_jogada_q;

    logic       tem_jogada;
    logic       jogada_feita;
    logic [3:0] memoria;
    logic       igual;
    logic       zera;
    logic       registra;
    logic       conta;

    assign tem_jogada   = |chaves;
    assign jogada_feita = tem_jogada & ~tem_jogada_q;
    assign memoria      = rom(contagem_q);
    assign igual        = (jogada_q == memoria);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= INICIAL;
            contagem_q   <= 4'h0;
            jogada_q     <= 4'h0;
            tem_jogada_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            tem_jogada_q <= tem_jogada;
            if (zera)
                contagem_q <= 4'h0;
            else if (conta)
                contagem_q <= contagem_q + 4'h1;
            if (zera)
                jogada_q <= 4'h0;
            else if (registra)
                jogada_q <= chaves;
        end
    end

    always_comb begin
        estado_d = estado_q;
        zera     = 1'b0;
        registra = 1'b0;
        conta    = 1'b0;
        unique case (estado_q)
            INICIAL:
                if (iniciar) estado_d = PREPARACAO;
            PREPARACAO: begin
                zera     = 1'b1;
                estado_d = ESPERA;
            end
            ESPERA:
                if (jogada_feita) estado_d = REGISTRA;
            REGISTRA: begin
                registra = 1'b1;
                estado_d = COMPARACAO;
            end
            COMPARACAO:
                if (!igual)
                    estado_d = FIM_ERRO;
                else if (contagem_q == 4'hF)
                    estado_d = FIM_ACERTO;
                else
                    estado_d = PROXIMO;
            PROXIMO: begin
                conta    = 1'b1;
                estado_d = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO:
                if (iniciar) estado_d = PREPARACAO;
            default:
                estado_d = INICIAL;
        endcase
    end

    assign acertou    = (estado_q == FIM_ACERTO);
    assign errou      = (estado_q == FIM_ERRO);
    assign pronto     = acertou | errou;
    assign leds       = chaves;
    assign db_clock   = clock;
    assign db_iniciar = iniciar;

`ifdef CIRCUITO_EXP4_DEBUG_EN
    assign db_igual       = igual;
    assign db_tem_jogada  = tem_jogada;
    assign db_contagem    = hex7(contagem_q);
    assign db_memoria     = hex7(memoria);
    assign db_estado      = hex7(estado_q);
    assign db_jogadafeita = hex7(jogada_q);
`else
    assign db_igual       = 1'b0;
    assign db_tem_jogada  = 1'b0;
    assign db_contagem    = 7'b1111111;
    assign db_memoria     = 7'b1111111;
    assign db_estado      = 7'b1111111;
    assign db_jogadafeita = 7'b1111111;
`endif

endmodule

// File: tb/tb_circuito_exp4.sv
// Directed self-checking bench for circuito_exp4.
// Expected debug outputs follow CIRCUITO_EXP4_DEBUG_EN.
module tb_circuito_exp4;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       acertou, errou, pronto;
    logic [3:0] leds;
    logic       db_igual, db_clock, db_iniciar, db_tem_jogada;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;

    circuito_exp4 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
        .db_igual(db_igual), .db_contagem(db_contagem),
        .db_memoria(db_memoria), .db_estado(db_estado),
        .db_jogadafeita(db_jogadafeita), .db_clock(db_clock),
        .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (dut.jogada_feita) pulses <= pulses + 1;

    logic [3:0] seq [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0100, 4'b0010, 4'b0001, 4'b0001,
                             4'b0010, 4'b0010, 4'b0100, 4'b0100,
                             4'b1000, 4'b1000, 4'b0001, 4'b0100};

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                               7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] seg(input logic [3:0] v);
`ifdef CIRCUITO_EXP4_DEBUG_EN
        return glyph[v];
`else
        return 7'h7F;
`endif
    endfunction

    function automatic logic dbg(input logic v);
`ifdef CIRCUITO_EXP4_DEBUG_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic play(input logic [3:0] v, input int hold);
        chaves = v;
        step(hold);
        chaves = 4'b0000;
        step(10);
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        step(1);
        chk("start_prep", 32'(dut.estado_q), 32'h1);
        iniciar = 1'b0;
        step(1);
        chk("start_wait", 32'(dut.estado_q), 32'h2);
        chk("start_cnt", 32'(dut.contagem_q), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        iniciar = 1'b0;
        chaves = 4'b0000;
        step(1);
        reset = 1'b0;
        chk("rst_acertou", 32'(acertou), 32'h0);
        chk("rst_errou", 32'(errou), 32'h0);
        chk("rst_pronto", 32'(pronto), 32'h0);
        chk("rst_state", 32'(dut.estado_q), 32'h0);
        chk("rst_cnt", 32'(dut.contagem_q), 32'h0);
        chk("rst_db_estado", 32'(db_estado), 32'(seg(4'h0)));
        chk("rst_db_cont", 32'(db_contagem), 32'(seg(4'h0)));

        // Held iniciar must start exactly one game.
        iniciar = 1'b1;
        step(5);
        iniciar = 1'b0;
        chk("ini_state", 32'(dut.estado_q), 32'h2);
        chk("ini_db_iniciar", 32'(db_iniciar), 32'h0);
        chaves = 4'b1010;
        #1;
        chk("leds", 32'(leds), 32'hA);
        chk("db_tem", 32'(db_tem_jogada), 32'(dbg(1'b1)));
        chaves = 4'b0000;
        step(1);

        for (int i = 0; i < 16; i++) begin
            play(seq[i], 5 + (i % 6));
            if (i < 15) begin
                chk("win_cnt", 32'(dut.contagem_q), 32'(i + 1));
                chk("win_pronto", 32'(pronto), 32'h0);
            end
        end
        chk("win_state", 32'(dut.estado_q), 32'hA);
        chk("win_cnt15", 32'(dut.contagem_q), 32'hF);
        chk("win_acertou", 32'(acertou), 32'h1);
        chk("win_pronto", 32'(pronto), 32'h1);
        chk("win_errou", 32'(errou), 32'h0);
        chk("win_db_estado", 32'(db_estado), 32'(seg(4'hA)));
        chk("win_db_cont", 32'(db_contagem), 32'(seg(4'hF)));
        chk("win_db_mem", 32'(db_memoria), 32'(seg(4'h4)));
        chk("win_db_jog", 32'(db_jogadafeita), 32'(seg(4'h4)));
        chk("win_db_igual", 32'(db_igual), 32'(dbg(1'b1)));

        // Plays outside espera are ignored; result is sticky.
        play(4'b0001, 6);
        chk("win_sticky", 32'(dut.estado_q), 32'hA);
        chk("win_sticky_ac", 32'(acertou), 32'h1);

        start_game();
        chk("restart_ac", 32'(acertou), 32'h0);
        play(4'b0001, 7);
        play(4'b0010, 7);
        play(4'b0100, 7);
        play(4'b1000, 7);
        play(4'b0001, 7);
        chk("lose_state", 32'(dut.estado_q), 32'hE);
        chk("lose_errou", 32'(errou), 32'h1);
        chk("lose_pronto", 32'(pronto), 32'h1);
        chk("lose_acertou", 32'(acertou), 32'h0);
        chk("lose_cnt", 32'(dut.contagem_q), 32'h4);
        chk("lose_db_cont", 32'(db_contagem), 32'(seg(4'h4)));
        chk("lose_db_estado", 32'(db_estado), 32'(seg(4'hE)));
        chk("lose_db_igual", 32'(db_igual), 32'h0);

        start_game();
        chk("err_clear", 32'(errou), 32'h0);
        chk("err_clear_pr", 32'(pronto), 32'h0);

        // Long hold: one pulse, four-cycle latency to the increment.
        begin
            int p0;
            p0 = pulses;
            chaves = 4'b0001;
            for (int i = 0; i < 20; i++) begin
                step(1);
                if (i == 0) chk("lat_reg", 32'(dut.estado_q), 32'h4);
                if (i == 1) chk("lat_cmp", 32'(dut.estado_q), 32'h5);
                if (i == 2) chk("lat_prox", 32'(dut.estado_q), 32'h6);
                if (i == 3) chk("lat_cnt", 32'(dut.contagem_q), 32'h1);
            end
            chaves = 4'b0000;
            step(10);
            chk("hold_pulses", 32'(pulses - p0), 32'h1);
            chk("hold_cnt", 32'(dut.contagem_q), 32'h1);
            chk("hold_state", 32'(dut.estado_q), 32'h2);
        end

        for (int i = 1; i < 7; i++) play(seq[i], 5);
        chk("mid_cnt", 32'(dut.contagem_q), 32'h7);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_rst_state", 32'(dut.estado_q), 32'h0);
        chk("mid_rst_cnt", 32'(dut.contagem_q), 32'h0);
        chk("mid_rst_pronto", 32'(pronto), 32'h0);

        // Multi-switch play compares as-is and loses.
        start_game();
        play(4'b0011, 5);
        chk("multi_state", 32'(dut.estado_q), 32'hE);
        chk("multi_errou", 32'(errou), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/circuito_exp4.md
# circuito_exp4

Sequence-memory game datapath plus control unit for the FPGA lab board. It holds a fixed 16-entry sequence of one-hot 4-bit plays in ROM. The player enters plays one at a time on 4 switches, and each play is compared against the current ROM entry. The block reports a win after 16 correct plays, or a loss on the first wrong play. It is the top level of the experiment and drives the board's LEDs and 7-segment debug displays.

## Interface
Parameters: none.
- clock  in  1  system clock (1 kHz on board)
- reset  in  1  synchronous, active-high
- iniciar  in  1  start/restart request, level-sampled
- chaves  in  4  player switches, one-hot play
- acertou  out  1  game won
- errou  out  1  game lost
- pronto  out  1  game finished
- leds  out  4  mirrors `chaves`
- db_igual  out  1  comparator output, `jogada_reg == mem[contagem]`
- db_contagem  out  7  7-seg display of the 4-bit play counter
- db_memoria  out  7  7-seg display of ROM data at the counter address
- db_estado  out  7  7-seg display of the FSM state code
- db_jogadafeita  out  7  7-seg display of the registered play
- db_clock  out  1  equals `clock`
- db_iniciar  out  1  equals `iniciar`
- db_tem_jogada  out  1  `|chaves`

## Operation
- ROM contents, addresses 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- Play detector:
  - `tem_jogada = |chaves`, registered every cycle.
  - `jogada_feita` is a 1-cycle pulse on the rising edge of `tem_jogada`.
  - Holding the switches produces exactly one pulse.
- FSM states and codes:
  - inicial = 0: outputs idle. `iniciar=1` goes to preparacao.
  - preparacao = 1: clears counter and play register, then goes to espera.
  - espera = 2: waits for `jogada_feita`, then goes to registra.
  - registra = 4: loads `chaves` into `jogada_reg`, then goes to comparacao.
  - comparacao = 5:
    - if not equal, go to fim_erro;
    - else if counter == 15, go to fim_acerto;
    - else go to proximo.
  - proximo = 6: counter += 1, then goes to espera.
  - fim_acerto = A: `pronto=1`, `acertou=1`. `iniciar=1` goes to preparacao.
  - fim_erro = E: `pronto=1`, `errou=1`. `iniciar=1` goes to preparacao.
- Outputs are Moore, decoded from state only.
- The 4-bit counter never wraps during a game, because 15 is terminal.
- Comparison is a 4-bit equality test. Non-one-hot plays, including multiple switches set, are compared as-is.
- 7-seg encoding is active-low, bit order gfedcba, standard hex glyphs 0–F. Example: 0 = 1000000, 1 = 1111001, A = 0001000, E = 0000110.

## Timing
- Reset, sampled on a clock edge, forces:
  - state inicial;
  - counter 0 and `jogada_reg` 0;
  - detector register 0;
  - `acertou = errou = pronto = 0`.
- Reset is accepted in any state, including mid-game.
- Latency from `chaves` going non-zero to the counter increment:
  - edge detect: 1 cycle;
  - registra: 1 cycle;
  - comparacao: 1 cycle;
  - proximo: 1 cycle.
- The next play is accepted only once the FSM is back in espera. Switches must return to 0000 between plays.
- A play whose edge arrives outside espera is ignored.
- `iniciar` held high for several cycles starts only one game. It is ignored outside inicial, fim_acerto and fim_erro.
- `acertou`, `errou` and `pronto` stay asserted until restart or reset.

## Configuration
- Macro `CIRCUITO_EXP4_DEBUG_EN`.
- When defined: all `db_*` outputs behave as specified.
- When undefined:
  - the four 7-seg debug outputs are driven 1111111 (blank);
  - `db_igual` and `db_tem_jogada` are driven 0;
  - `db_clock` and `db_iniciar` are still passed through.
- Game behaviour is identical in both builds.

## Test plan
- Reset for 1 cycle:
  - `acertou=errou=pronto=0`;
  - `db_estado` shows 0;
  - `db_contagem` shows 0.
- `iniciar=1` for 5 cycles, then play the ROM sequence, each play held 5–10 cycles with 10 idle cycles between plays:
  - counter reaches 15;
  - state reaches A;
  - `acertou=1`, `pronto=1`, `errou=0`.
- Correct plays 0001, 0010, 0100, 1000, then 0001 as play 5:
  - state reaches E;
  - `errou=1`, `pronto=1`;
  - `db_contagem` shows 4.
- Hold 0001 for 20 cycles as play 1: exactly one `jogada_feita` pulse, counter becomes 1.
- From fim_erro, pulse `iniciar`: state passes through 1 to 2, counter 0, `errou=0`.
- Assert reset mid-game at counter 7: on the next edge, state 0 and counter 0.
